// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int DMEM_ADDR_WIDTH  = 10;
  localparam int DMEM_WAIT_CYCLES = 2;
  localparam int CNT_WIDTH        = 4;

  // Request fields captured at the acceptance handshake.
  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_ram_bank.sv
// rtl/dmem_ram_bank.sv - synchronous single-port 32-bit RAM with byte enables
module dmem_ram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Read-first: a same-edge write is seen by the next read, not this one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding CPU data-memory responder with wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  dmem_req_t             req_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign addr_ok = (state == IDLE);
  assign accept  = req && addr_ok;
  assign data_ok = (state == RESP);

  // Point the RAM at the incoming index on the acceptance edge so read data
  // is ready even with zero wait states; otherwise hold the latched index.
  assign ram_addr = accept ? addr[ADDR_WIDTH+1:2] : idx_q;
  assign ram_we   = (state == RESP) && req_q.wr;

  assign rdata = (data_ok && !req_q.wr) ? ram_q : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            req_q.wr    <= wr;
            req_q.wstrb <= wstrb;
            req_q.wdata <= wdata;
            idx_q       <= addr[ADDR_WIDTH+1:2];
            cnt         <= CNT_WIDTH'(WAIT_CYCLES);
            state       <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  dmem_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (req_q.wstrb),
    .addr (ram_addr),
    .wdata(req_q.wdata),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (wait=2 and wait=0 instances)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req     [2];
  logic        wr      [2];
  logic [3:0]  wstrb   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata   [2];

  logic [31:0] model [2][1024];

  int applied    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
  );

  typedef struct {
    bit          w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Word index after aliasing: addresses repeat every 4 KiB, low two bits ignored.
  function automatic int widx(input logic [31:0] a);
    return int'(a % 32'd4096) / 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(input int d, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] wd);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[d][widx(a)][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after data_ok.
  task automatic access(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    int  n;
    bit  early_ok;
    rd = 32'h0;
    req[d] = 1'b1; wr[d] = w; wstrb[d] = s; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (!addr_ok[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'b0, addr_ok[d]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom; wstrb[d] = 4'($urandom);
    wr[d] = 1'($urandom);
    n = 1;
    early_ok = 1'b0;
    while (!data_ok[d] && n < 40) begin
      if (addr_ok[d]) early_ok = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("latency", n, wait_of(d) + 1);
    chk("addr_ok_in_wait", {31'b0, early_ok}, 32'd0);
    chk("addr_ok_in_resp", {31'b0, addr_ok[d]}, 32'd0);
    rd = rdata[d];
    if (w) chk("wr_rdata_zero", rdata[d], 32'h0);
    @(negedge clk);
    chk("data_ok_one_cycle", {31'b0, data_ok[d]}, 32'd0);
    chk("addr_ok_back", {31'b0, addr_ok[d]}, 32'd1);
    if (w) model_write(d, s, a, wd);
  endtask

  // req held high across three reads of 0x0, 0x4, 0x8.
  task automatic back_to_back(input int d);
    int          cyc, nd, acc;
    int          dcyc [3];
    logic [31:0] dv   [3];
    bit          pend, bad_ok;
    cyc = 0; nd = 0; acc = 0; pend = 1'b0; bad_ok = 1'b0;
    req[d] = 1'b1; wr[d] = 1'b0; wstrb[d] = 4'h0; addr[d] = 32'h0;
    while (nd < 3 && cyc < 60) begin
      if (data_ok[d]) begin
        dcyc[nd] = cyc;
        dv[nd]   = rdata[d];
        nd++;
        if (addr_ok[d]) bad_ok = 1'b1;
      end
      pend = req[d] && addr_ok[d];
      if (pend) acc++;
      @(negedge clk);
      cyc++;
      if (pend) begin
        if (acc == 3) req[d] = 1'b0;
        else addr[d] = 32'(acc * 4);
      end
    end
    chk("b2b_pulses", nd, 3);
    chk("b2b_accepts", acc, 3);
    chk("b2b_overlap", {31'b0, bad_ok}, 32'd0);
    if (nd == 3) begin
      chk("b2b_first_lat", dcyc[0], wait_of(d) + 1);
      for (int i = 0; i < 2; i++) chk("b2b_spacing", dcyc[i+1] - dcyc[i], wait_of(d) + 2);
      for (int i = 0; i < 3; i++) chk("b2b_data", dv[i], model[d][i]);
    end
  endtask

  initial begin
    vec_t        tbl [10];
    logic [31:0] rd;
    logic [31:0] a, wd;
    logic [3:0]  s;
    bit          w, seen;
    int          wi;

    tbl[0] = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0};
    tbl[1] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    tbl[2] = '{1'b1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 32'h0};
    tbl[3] = '{1'b1, 4'h5, 32'h0000_0020, 32'h1122_3344, 32'h0};
    tbl[4] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'hAA22_CC44};
    tbl[5] = '{1'b1, 4'hF, 32'h0000_0004, 32'h5555_AAAA, 32'h0};
    tbl[6] = '{1'b0, 4'h0, 32'h0000_1007, 32'h0,         32'h5555_AAAA};
    tbl[7] = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
    tbl[8] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'hAA22_CC44};
    tbl[9] = '{1'b0, 4'h0, 32'hFFFF_F012, 32'h0,         32'h1234_5678};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_data_ok", {31'b0, data_ok[d]}, 32'd0);
      chk("reset_rdata", rdata[d], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("reset_addr_ok", {31'b0, addr_ok[d]}, 32'd1);

    // Known contents for the low 64 words of both instances.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) access(d, 1'b1, 4'hF, 32'(i * 4), $urandom, rd);

    for (int i = 0; i < 10; i++) begin
      access(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].wd, rd);
      chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    back_to_back(0);

    // Abort a write by resetting during its wait states.
    access(0, 1'b1, 4'hF, 32'h0000_0040, 32'h0, rd);
    req[0] = 1'b1; wr[0] = 1'b1; wstrb[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_data_ok", {31'b0, data_ok[0]}, 32'd0);
    chk("rst_mid_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (data_ok[0]) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_data_ok", {31'b0, seen}, 32'd0);
    access(0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, rd);
    chk("rst_write_aborted", rd, 32'h0);

    access(1, 1'b0, 4'h0, 32'h0000_0008, 32'h0, rd);
    chk("zero_wait_read", rd, model[1][2]);
    back_to_back(1);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        wi = int'($urandom_range(0, 63));
        a  = ($urandom & 32'hFFFF_F000) | 32'(wi * 4) | 32'($urandom_range(0, 3));
        w  = 1'($urandom);
        s  = 4'($urandom);
        wd = $urandom;
        access(d, w, s, a, wd, rd);
        if (!w) chk($sformatf("rand_d%0d_w%0d", d, wi), rd, model[d][wi]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the number of word-address bits (2^ADDR_WIDTH 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the extra wait states per access (legal 0..15).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  CPU request valid.
REQ-006 wr  in  1  1 = write, 0 = read.
REQ-007 wstrb  in  4  byte write enables (bit i -> byte i, little-endian).
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  write data.
REQ-010 addr_ok  out  1  request accepted this cycle when req is also high.
REQ-011 data_ok  out  1  one-cycle response pulse.
REQ-012 rdata  out  32  read data, valid while data_ok=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 addr_ok SHALL be 1 only in IDLE, and req&&addr_ok SHALL be the acceptance handshake.
REQ-015 On acceptance, the block SHALL latch wr, wstrb, wdata and word index addr[ADDR_WIDTH+1:2], and load the wait counter with WAIT_CYCLES.
REQ-016 Next state after acceptance SHALL be WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter goes from 1 to 0.
REQ-018 For an access accepted at edge k, data_ok SHALL be high during cycle k+1+WAIT_CYCLES, for exactly one cycle.
REQ-019 RESP SHALL always return to IDLE on the next edge, so only one outstanding access is allowed and addr_ok=0 in WAIT and RESP.
REQ-020 Requests arriving while addr_ok=0 SHALL be ignored, and the CPU SHALL hold req until acceptance.
REQ-021 For a read, rdata SHALL equal the array word at the latched index during the data_ok cycle.
REQ-022 For a write, bytes with wstrb[i]=1 SHALL be updated on the edge ending the data_ok cycle, and bytes with wstrb[i]=0 SHALL be unchanged.
REQ-023 For a write, rdata SHALL be 32'h0 while data_ok=1.
REQ-024 A write with wstrb=4'b0000 SHALL complete normally with no array change.
REQ-025 addr[1:0] and addr[31:ADDR_WIDTH+2] SHALL be ignored, so addresses alias modulo 2^(ADDR_WIDTH+2) bytes.
REQ-026 A read accepted in the IDLE cycle immediately after a write's data_ok SHALL return the newly written data.
REQ-027 Address, data and strobe inputs SHALL be sampled only at acceptance, so later changes have no effect on the access in flight.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, counter=0, data_ok=0, rdata=32'h0, addr_ok=1 after release.
REQ-029 A reset during WAIT or RESP SHALL abort the access, so a pending write does not modify the array and no data_ok is issued.
REQ-030 Array contents SHALL NOT be reset; bench reads of unwritten words are don't-care.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the ADDR_WIDTH/WAIT_CYCLES defaults and the wait-counter width (4).
REQ-032 Storage SHALL be a sub-module dmem_ram_bank: synchronous single-port, 32-bit, 4 byte enables, no reset.
REQ-033 The FSM, counter and latches SHALL be in dmem_responder.

Verification
REQ-034 Read latency: WAIT_CYCLES=2; write 0x1234_5678 to addr 0x10 with wstrb=4'hF; then read 0x10, accepted at edge k -> data_ok only in cycle k+3, rdata=0x1234_5678.
REQ-035 Byte strobes: word 0x20 = 0xAABB_CCDD; write 0x1122_3344 with wstrb=4'b0101; read 0x20 -> 0xAA22_CC44.
REQ-036 Back-to-back: req held high for three reads (0x0, 0x4, 0x8) -> addr_ok only in IDLE cycles, three data_ok pulses spaced WAIT_CYCLES+2 cycles apart, data in order.
REQ-037 Zero wait: WAIT_CYCLES=0; read accepted at edge k -> data_ok in cycle k+1, and the next acceptance at edge k+2 at the earliest.
REQ-038 Reset mid-write: write 0xDEAD_BEEF to 0x40 (prior value 0x0), assert rst during WAIT -> no data_ok; after release, read 0x40 -> 0x0.
REQ-039 Aliasing/misalign: ADDR_WIDTH=10; write 0x5555_AAAA to 0x0000_0004; read 0x0000_1007 -> 0x5555_AAAA.
